pwm_bank: RTL
=============

# pwm_bank

Parametrised multi-channel PWM controller driven by 16-bit command words from the SPI receiver. It replaces the single-channel PWM plus separate clock divider with one block containing:
- a shared prescaler and period counter;
- NUM_CH double-buffered compare channels;
- per-channel enable and polarity;
- a synchronous restart.

It sits between `spi_interface` (`data`/`data_rdy`) and the `uo_out` pins.

## Interface
- NUM_CH, 8, number of PWM channels (1..8)
- CMP_WIDTH, 8, compare/counter width in bits (1..12)
- DIV_WIDTH, 3, prescaler setting width in bits (1..12)

- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- wr_valid  in  1  single-cycle strobe: wr_data holds a command
- wr_data  in  16  command word; [15:12] address, [11:0] payload
- pwm_out  out  NUM_CH  registered PWM outputs
- period_start  out  1  one-cycle pulse when the period counter wraps or restarts
- cfg_err  out  1  one-cycle pulse for a command to an unmapped address

## Operation
Address map (addr = wr_data[15:12]):
- 0x0..NUM_CH-1: compare shadow[addr] <= payload[CMP_WIDTH-1:0]
- NUM_CH..0x7: unmapped
- 0x8: div <= payload[DIV_WIDTH-1:0]; prescaler count cleared
- 0x9: en <= payload[NUM_CH-1:0]
- 0xA: pol <= payload[NUM_CH-1:0]
- 0xB: if payload[0]=1, restart. If payload[0]=0, no action and no error.
- 0xC..0xF: unmapped

Prescaler and counter:
- Prescaler counts 0..div. It asserts tick when count == div, then returns to 0. div=0 means tick every cycle.
- Period counter cnt (CMP_WIDTH bits) increments on tick and wraps from 2^CMP_WIDTH-1 to 0.

Wrap:
- Occurs on a tick with cnt at max.
- All active[i] <= shadow[i].
- period_start pulses in the same cycle the counter reads 0.

Restart (0xB, bit0=1):
- cnt and prescaler count cleared.
- All active <= shadow.
- period_start pulses.

Channel output, registered: pwm_out[i] <= en[i] ? ((cnt < active[i]) ^ pol[i]) : pol[i].
- compare=0 gives a constant inactive level.
- compare=2^W-1 gives active for all but one tick per period.
- 100% duty is not representable.

Reset values:
- shadow, active, div, cnt, prescaler count: 0
- en: all 1; pol: 0
- pwm_out, period_start, cfg_err: 0

## Timing
- Command write lands on the rising edge that samples wr_valid. cfg_err is high the cycle after that edge.
- Compare write: becomes visible at the next wrap/restart, never mid-period.
- en/pol write: affects pwm_out from the second rising edge after wr_valid.
- Compare write in the same cycle as a wrap: active loads the pre-write shadow. The new value takes effect one period later.
- Divider write in the same cycle as a tick: the tick still counts; the new div applies from the next cycle.
- Restart coinciding with a wrap: single period_start pulse, cnt=0.
- Back-to-back commands on consecutive cycles are all accepted; there is no backpressure.
- Async reset mid-period: all state returns to reset values immediately. After release, the first wrap occurs 2^CMP_WIDTH·(div+1) cycles later.
- Period length = 2^CMP_WIDTH·(div+1) clk cycles. pwm_out lags cnt by one cycle.

## Structure
- `pwm_bank_pkg` holds the address constants: ADDR_DIV=4'h8, ADDR_EN=4'h9, ADDR_POL=4'hA, ADDR_CTRL=4'hB. It also holds the command word widths ADDR_MSB=15, ADDR_LSB=12, PAYLOAD_W=12.
- Sub-module `pwm_channel`, one instance per channel via a generate loop. It contains the shadow and active registers, the comparator and the output flop. Inputs: cnt, load, en, pol, write strobe, data.
- The prescaler, period counter and address decode live in `pwm_bank`.

## Test plan
- Reset release, defaults -> pwm_out=0 for a full period. period_start first pulses 256 cycles after reset release (CMP_WIDTH=8, div=0).
- Write 0x0040, div=0 -> no change until the next wrap. Then pwm_out[0] is high for 64 of every 256 cycles; period_start spacing is 256.
- Write 0x8003, then 0x1080 -> period 1024 cycles. pwm_out[1] is high 512 cycles per period.
- Mid-period write 0x2010, then 0xA004 -> pwm_out[2] inverts two edges after the 0xA004 strobe. Compare 0x10 is applied only at the next wrap.
- Write 0x9000 -> all outputs go to pol levels. Write 0x00FF, then 0xB001 -> immediate restart and period_start. pwm_out[0] remains idle until the enable is rewritten.
- Write 0xC000, and 0x7000 with NUM_CH=4 -> each gives a one-cycle cfg_err pulse with no state change. Compare 0x00 and 0xFF checked for the no-toggle and 255/256 duty cases.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared constants for the pwm_bank command interface: address map and
// command word layout.
package pwm_bank_pkg;

    localparam logic [3:0] ADDR_DIV  = 4'h8;
    localparam logic [3:0] ADDR_EN   = 4'h9;
    localparam logic [3:0] ADDR_POL  = 4'hA;
    localparam logic [3:0] ADDR_CTRL = 4'hB;

    localparam int ADDR_MSB  = 15;
    localparam int ADDR_LSB  = 12;
    localparam int PAYLOAD_W = 12;

    typedef struct packed {
        logic [ADDR_MSB-ADDR_LSB:0] addr;
        logic [PAYLOAD_W-1:0]       payload;
    } cmd_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered compare (shadow -> active on load),
// comparator against the shared period counter, registered output.
module pwm_channel #(
    parameter int CMP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CMP_WIDTH-1:0] cnt_i,
    input  logic                 load_i,
    input  logic                 en_i,
    input  logic                 pol_i,
    input  logic                 wr_i,
    input  logic [CMP_WIDTH-1:0] data_i,
    output logic                 pwm_o
);

    logic [CMP_WIDTH-1:0] shadow_q, active_q;
    logic                 pwm_q;

    // load samples the pre-write shadow, so a write coinciding with a wrap
    // only takes effect one period later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            if (load_i) active_q <= shadow_q;
            if (wr_i)   shadow_q <= data_i;
            pwm_q <= en_i ? ((cnt_i < active_q) ^ pol_i) : pol_i;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM controller: command decode, shared prescaler and period
// counter, and an array of double-buffered compare channels.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int CMP_WIDTH = 8,
    parameter int DIV_WIDTH = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [15:0]       wr_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start,
    output logic              cfg_err
);

    cmd_t cmd;
    assign cmd = cmd_t'(wr_data);

    logic [DIV_WIDTH-1:0] div_q, pre_q, pre_d;
    logic [CMP_WIDTH-1:0] cnt_q, cnt_d;
    logic [NUM_CH-1:0]    en_q, pol_q;
    logic                 ps_q, err_q;

    logic tick, wrap, restart, load, wr_div, wr_en, wr_pol, mapped;

    assign tick    = (pre_q == div_q);
    assign wrap    = tick && (&cnt_q);
    assign wr_div  = wr_valid && (cmd.addr == ADDR_DIV);
    assign wr_en   = wr_valid && (cmd.addr == ADDR_EN);
    assign wr_pol  = wr_valid && (cmd.addr == ADDR_POL);
    assign restart = wr_valid && (cmd.addr == ADDR_CTRL) && cmd.payload[0];
    assign load    = wrap || restart;
    assign mapped  = (int'(cmd.addr) < NUM_CH) ||
                     ((cmd.addr >= ADDR_DIV) && (cmd.addr <= ADDR_CTRL));

    // A divider write clears the prescaler but the tick of that cycle
    // (computed from the old div) still advances the counter.
    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (restart || wr_div) pre_d = '0;
        cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
        if (restart) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            pre_q <= '0;
            cnt_q <= '0;
            en_q  <= '1;
            pol_q <= '0;
            ps_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
            if (wr_div) div_q <= cmd.payload[DIV_WIDTH-1:0];
            if (wr_en)  en_q  <= cmd.payload[NUM_CH-1:0];
            if (wr_pol) pol_q <= cmd.payload[NUM_CH-1:0];
            ps_q  <= load;
            err_q <= wr_valid && !mapped;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(.CMP_WIDTH(CMP_WIDTH)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .cnt_i (cnt_q),
            .load_i(load),
            .en_i  (en_q[i]),
            .pol_i (pol_q[i]),
            .wr_i  (wr_valid && (cmd.addr == 4'(i))),
            .data_i(cmd.payload[CMP_WIDTH-1:0]),
            .pwm_o (pwm_out[i])
        );
    end

    assign period_start = ps_q;
    assign cfg_err      = err_q;

    logic unused_payload;
    assign unused_payload = ^cmd.payload;

endmodule
